// File: rtl/dms_pkg.sv
// dms_pkg -- shared constants for the dot-matrix digit scanner.
//   ROW_CNT    : matrix rows (fixed at 8)
//   colour_e   : colour-select constants (green / yellow / red)
//   GLYPH      : 8x8 font for digits 0..7, GLYPH[digit][row], bit 7 = leftmost column
//   colour_of(): digit -> colour select
package dms_pkg;

    localparam int ROW_CNT   = 8;
    localparam int ROW_IDX_W = $clog2(ROW_CNT);

    typedef enum logic [1:0] {
        COL_GREEN  = 2'd0,
        COL_YELLOW = 2'd1,
        COL_RED    = 2'd2
    } colour_e;

    localparam logic [7:0] GLYPH [8][8] = '{
        '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},  // 0
        '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},  // 1
        '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},  // 2
        '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},  // 3
        '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},  // 4
        '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},  // 5
        '{8'h3C, 8'h66, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h3C, 8'h00},  // 6
        '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00}   // 7
    };

    // Last seconds of the countdown go yellow, zero goes red.
    function automatic colour_e colour_of(input logic [2:0] digit);
        if (digit == 3'd0)      return COL_RED;
        else if (digit <= 3'd2) return COL_YELLOW;
        else                    return COL_GREEN;
    endfunction

endpackage

// File: rtl/dms_blink.sv
// dms_blink -- half-period counter and blink phase for the zero-digit flash.
//   clk, rst  : clock, async active-high reset
//   restart   : clear counter and force the lit half (digit just reached 0)
//   blink_on  : 1 = lit half, 0 = dark half; resets to 1
module dms_blink #(
    parameter int BLINK_HALF = 250
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic blink_on
);

    localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            blink_on <= 1'b1;
        end else if (restart) begin
            cnt      <= '0;
            blink_on <= 1'b1;
        end else if (cnt == CW'(BLINK_HALF - 1)) begin
            cnt      <= '0;
            blink_on <= ~blink_on;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dot_matrix_scan.sv
// dot_matrix_scan -- row-multiplexed 8x8 bicolour digit display driver.
//   clk, rst    : clock (1 kHz nominal), async active-high reset
//   num[2:0]    : digit to show; sampled once per frame
//   row[7:0]    : one-hot active-low row select, bit k = row k (row 0 on top)
//   colr[7:0]   : red column data, active-high, bit 7 = leftmost
//   colg[7:0]   : green column data, same order
//   frame_start : pulse in the cycle the digit is captured
// Each row slot is a blank cycle followed by a drive cycle; 8 slots per frame.
// Build option DOT_MATRIX_SCAN_BLINK_EN: flash digit 0 with BLINK_HALF-cycle
// half-periods; without it digit 0 is steady red.
module dot_matrix_scan
    import dms_pkg::*;
#(
    parameter int BLINK_HALF = 250,
    parameter int ROW_CNT    = dms_pkg::ROW_CNT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] num,
    output logic [7:0] row,
    output logic [7:0] colr,
    output logic [7:0] colg,
    output logic       frame_start
);

    if (ROW_CNT != 8) begin : g_bad_row_cnt
        $error("dot_matrix_scan: ROW_CNT must be 8");
    end
    if (BLINK_HALF < 2) begin : g_bad_blink_half
        $error("dot_matrix_scan: BLINK_HALF must be >= 2");
    end

    typedef enum logic {PH_BLANK = 1'b0, PH_DRIVE = 1'b1} phase_e;

    phase_e                 phase, phase_n;
    logic [ROW_IDX_W-1:0]   row_idx, row_idx_n;
    logic [2:0]             num_q, num_q_n;
    logic [7:0]             row_n, colr_n, colg_n;
    logic                   fs_n;
    logic [7:0]             glyph_row;
    logic                   lit;

`ifdef DOT_MATRIX_SCAN_BLINK_EN
    logic blink_on;
    logic blink_restart;

    // Digit goes nonzero -> zero at this capture: start the flash on a lit half.
    assign blink_restart = (phase == PH_BLANK) && (row_idx == '0) &&
                           (num == 3'd0) && (num_q != 3'd0);

    dms_blink #(.BLINK_HALF(BLINK_HALF)) u_blink (
        .clk      (clk),
        .rst      (rst),
        .restart  (blink_restart),
        .blink_on (blink_on)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase       <= PH_BLANK;
            row_idx     <= '0;
            num_q       <= 3'd0;
            row         <= 8'hFF;
            colr        <= 8'h00;
            colg        <= 8'h00;
            frame_start <= 1'b0;
        end else begin
            phase       <= phase_n;
            row_idx     <= row_idx_n;
            num_q       <= num_q_n;
            row         <= row_n;
            colr        <= colr_n;
            colg        <= colg_n;
            frame_start <= fs_n;
        end
    end

    // Outputs describe the slot/phase held in state now; they appear after the edge.
    always_comb begin
        phase_n   = phase;
        row_idx_n = row_idx;
        num_q_n   = num_q;
        row_n     = 8'hFF;
        colr_n    = 8'h00;
        colg_n    = 8'h00;
        fs_n      = 1'b0;
        glyph_row = GLYPH[num_q][row_idx];
        lit       = 1'b1;
`ifdef DOT_MATRIX_SCAN_BLINK_EN
        lit       = blink_on || (num_q != 3'd0);
`endif
        case (phase)
            PH_BLANK: begin
                phase_n = PH_DRIVE;
                // Digit only changes at a frame boundary so a frame never tears.
                if (row_idx == '0) begin
                    num_q_n = num;
                    fs_n    = 1'b1;
                end
            end
            default: begin
                phase_n   = PH_BLANK;
                row_idx_n = row_idx + 1'b1;  // 7 -> 0 wraps with the width
                row_n     = ~(8'h01 << row_idx);
                if (lit) begin
                    case (colour_of(num_q))
                        COL_RED:    colr_n = glyph_row;
                        COL_YELLOW: begin
                            colr_n = glyph_row;
                            colg_n = glyph_row;
                        end
                        default:    colg_n = glyph_row;
                    endcase
                end
            end
        endcase
    end

endmodule

// File: tb/tb_dot_matrix_scan.sv
module tb_dot_matrix_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] num = 3'd0;
    logic [7:0] row, colr, colg;
    logic       frame_start;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] gl [8][8] = '{
        '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
        '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h66, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00}
    };

    dot_matrix_scan #(.BLINK_HALF(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .num         (num),
        .row         (row),
        .colr        (colr),
        .colg        (colg),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Advance to the next frame_start cycle (sampled on negedge), bounded.
    task automatic wait_frame(input string tag);
        int n = 0;
        @(negedge clk);
        while (frame_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (frame_start !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL %s frame_start timeout got=%b exp=1", tag, frame_start);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({row, colr, colg, frame_start} !== {8'hFF, 8'h00, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_hold got=%h/%h/%h/%b exp=ff/00/00/0", row, colr, colg, frame_start);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({row, frame_start} !== {8'hFF, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_first_edge got row=%h fs=%b exp row=ff fs=1", row, frame_start);
        end
        @(negedge clk);
        vectors++;
        if ({row, frame_start} !== {8'hFE, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_slot0 got row=%h fs=%b exp row=fe fs=0", row, frame_start);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (row !== 8'hFB) begin
            miscompares++;
            $display("FAIL reset_pre_slot2 got row=%h exp=fb", row);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({row, colr, colg, frame_start} !== {8'hFF, 8'h00, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_midframe got=%h/%h/%h/%b exp=ff/00/00/0", row, colr, colg, frame_start);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({row, frame_start} !== {8'hFF, 1'b1}) begin
            miscompares++;
            $display("FAIL reset_release got row=%h fs=%b exp row=ff fs=1", row, frame_start);
        end
    endtask

    task automatic test_scan();
        logic [7:0] er, ec;
        int k;
        num = 3'd5;
        wait_frame("scan");
        for (int c = 0; c < 32; c++) begin
            if (c > 0) @(negedge clk);
            k  = (c % 16) / 2;
            er = (c % 2 == 1) ? ~(8'h01 << k) : 8'hFF;
            ec = (c % 2 == 1) ? gl[5][k] : 8'h00;
            vectors++;
            if ({row, colr, colg, frame_start} !== {er, 8'h00, ec, (c % 16 == 0)}) begin
                miscompares++;
                $display("FAIL scan c=%0d got=%h/%h/%h/%b exp=%h/00/%h/%b",
                         c, row, colr, colg, frame_start, er, ec, (c % 16 == 0));
            end
        end
    endtask

    task automatic test_tearing();
        logic [7:0] er, eg, ex;
        int k;
        num = 3'd5;
        wait_frame("tearing");
        for (int c = 0; c < 32; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 6) num = 3'd1;
            k  = (c % 16) / 2;
            er = (c % 2 == 1) ? ~(8'h01 << k) : 8'hFF;
            ex = (c % 2 == 1) ? gl[(c < 16) ? 5 : 1][k] : 8'h00;
            eg = ex;
            vectors++;
            if ({row, colr, colg} !== {er, (c < 16) ? 8'h00 : ex, eg}) begin
                miscompares++;
                $display("FAIL tearing c=%0d got=%h/%h/%h exp=%h/%h/%h",
                         c, row, colr, colg, er, (c < 16) ? 8'h00 : ex, eg);
            end
        end
    endtask

    task automatic test_colour();
        int k;
        num = 3'd2;
        wait_frame("colour2");
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            if (c % 2 == 1) begin
                k = c / 2;
                vectors++;
                if (colr !== colg || colg !== gl[2][k]) begin
                    miscompares++;
                    $display("FAIL colour2 slot=%0d got r=%h g=%h exp r=g=%h", k, colr, colg, gl[2][k]);
                end
            end
        end
        num = 3'd7;
        wait_frame("colour7");
        for (int c = 0; c < 16; c++) begin
            if (c > 0) @(negedge clk);
            if (c % 2 == 1) begin
                k = c / 2;
                vectors++;
                if ({colr, colg} !== {8'h00, gl[7][k]}) begin
                    miscompares++;
                    $display("FAIL colour7 slot=%0d got r=%h g=%h exp r=00 g=%h", k, colr, colg, gl[7][k]);
                end
            end
        end
    endtask

`ifdef DOT_MATRIX_SCAN_BLINK_EN
    // Half-period 4: D slots 0,1 lit, 2,3 dark, repeating every 4 slots.
    task automatic test_blink();
        logic [7:0] er, ec;
        int k;
        num = 3'd1;
        wait_frame("blink_pre");
        num = 3'd0;
        wait_frame("blink");
        for (int c = 0; c < 32; c++) begin
            if (c > 0) @(negedge clk);
            k  = (c % 16) / 2;
            er = (c % 2 == 1) ? ~(8'h01 << k) : 8'hFF;
            ec = ((c % 2 == 1) && (k % 4 < 2)) ? gl[0][k] : 8'h00;
            vectors++;
            if ({row, colr, colg} !== {er, ec, 8'h00}) begin
                miscompares++;
                $display("FAIL blink c=%0d got=%h/%h/%h exp=%h/%h/00", c, row, colr, colg, er, ec);
            end
        end
    endtask
`else
    task automatic test_zero_steady();
        logic [7:0] er, ec;
        int k;
        num = 3'd0;
        wait_frame("zero");
        for (int c = 0; c < 48; c++) begin
            if (c > 0) @(negedge clk);
            k  = (c % 16) / 2;
            er = (c % 2 == 1) ? ~(8'h01 << k) : 8'hFF;
            ec = (c % 2 == 1) ? gl[0][k] : 8'h00;
            vectors++;
            if ({row, colr, colg} !== {er, ec, 8'h00}) begin
                miscompares++;
                $display("FAIL zero c=%0d got=%h/%h/%h exp=%h/%h/00", c, row, colr, colg, er, ec);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_scan();
        test_tearing();
        test_colour();
`ifdef DOT_MATRIX_SCAN_BLINK_EN
        test_blink();
`else
        test_zero_steady();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dot_matrix_scan.md
DOT_MATRIX_SCAN -- requirements
Module: dot_matrix_scan

Interface
REQ-001 Parameter: BLINK_HALF, 250, clk cycles per blink half-period (zero-digit flash); must be >= 2.
REQ-002 Parameter: ROW_CNT, 8, matrix rows; fixed at 8, not to be overridden.
REQ-003 Port: clk  input  1  system clock (1 kHz nominal).
REQ-004 Port: rst  input  1  reset; asynchronous, active-high.
REQ-005 Port: num  input  3  digit 0..7 from the countdown counter; may change on any cycle.
REQ-006 Port: row  output  8  row select, one-hot active-low; bit k drives row k, row 0 is the top row.
REQ-007 Port: colr  output  8  red column data, active-high; bit 7 is the leftmost column.
REQ-008 Port: colg  output  8  green column data, active-high; same bit order as colr.
REQ-009 Port: frame_start  output  1  one-cycle pulse in the cycle num is captured.

Function
REQ-010 Each row slot lasts 2 cycles: phase B (blank), then phase D (drive); one frame = 8 slots = 16 cycles.
REQ-011 In phase B, row shall be 8'hFF and colr/colg 8'h00 (anti-ghosting dead time).
REQ-012 In phase D of slot k, row = ~(8'h01 << k); columns = glyph[num_q][k], masked by colour.
REQ-013 Row index increments 0..7 after each phase D and wraps 7 -> 0 with no idle cycle.
REQ-014 num_q (latched digit) is loaded from num only in phase B of slot 0; frame_start = 1 in exactly that cycle.
REQ-015 A num change mid-frame shall not alter the current frame; it appears from the next frame.
REQ-016 Colour from num_q: 3..7 green only (colr=0); 1..2 red and green (yellow); 0 red only (colg=0).
REQ-017 Blink counter counts 0..BLINK_HALF-1, then wraps and toggles blink_on; blink_on resets to 1.
REQ-018 When num_q becomes 0 from a nonzero value, counter clears and blink_on sets to 1 in that cycle (first half lit).
REQ-019 If num_q == 0 and blink_on == 0, columns shall be 8'h00 during phase D; row scanning continues unchanged.
REQ-020 For num_q != 0 blink_on is ignored; the counter keeps running freely.
REQ-021 All outputs shall be registered: the value for a cycle is computed from state at the preceding edge.

Reset
REQ-022 On rst: row=8'hFF, colr=8'h00, colg=8'h00, frame_start=0, row index 0, phase B, num_q=0, blink counter 0, blink_on=1.
REQ-023 rst asserted mid-frame returns to the REQ-022 state immediately; after release, the first edge is slot 0 phase B with num captured.

Configuration
REQ-024 Macro DOT_MATRIX_SCAN_BLINK_EN: when defined, REQ-017..REQ-020 apply.
REQ-025 Without DOT_MATRIX_SCAN_BLINK_EN, the blink counter and blink_on are absent and digit 0 is shown steadily in red.

Structure
REQ-026 Package dms_pkg holds: ROW_CNT, the 8x8 glyph table for digits 0..7, and the colour-select constants.
REQ-027 Required glyph rows (0..7): digit 0 = 3C 66 6E 76 66 66 3C 00; digit 1 = 18 38 18 18 18 18 7E 00; digit 5 = 7E 60 7C 06 06 66 3C 00.
REQ-028 The remaining digits are legible 8x8 numerals defined in dms_pkg.
REQ-029 One sub-module, dms_blink (counter plus blink_on), instantiated only under DOT_MATRIX_SCAN_BLINK_EN; scan and glyph logic stay in the top.

Verification
REQ-030 Reset: assert rst mid-frame -> next sample row=FF, colr=00, colg=00; after release, frame_start at the first edge.
REQ-031 Scan: hold num=5 for 2 frames -> phase D rows FE,FD,...,7F; colg=7E,60,7C,06,06,66,3C,00; colr=00; blank cycles FF/00/00.
REQ-032 Tearing: num=5 at frame start, change to 1 during slot 3 -> slots 3..7 still show digit 5; next frame colg=colr=18,38,... (yellow).
REQ-033 Colour: num=2 -> colr==colg in every D cycle; num=7 -> colr=00 throughout.
REQ-034 Blink (BLINK_HALF=4, macro on): num 1 -> 0 -> digit 0 red lit 4 cycles, dark 4, lit 4; row keeps scanning, colg=00.
REQ-035 Macro off: num=0 for 3 frames -> colr = 3C,66,6E,76,66,66,3C,00 every frame, never blanked.
